immgen_pipe: RTL and testbench

Registered, parametrised immediate generator for the decode→execute boundary.
- Widens immediate generation to XLEN (32 or 64).
- Adds CSR-zimm and shift-amount types and an illegal-type flag.
- Carries a sideband tag alongside each immediate.
- Decouples decode from execute with a valid/ready handshake, a 2-entry skid buffer and a flush.

---
 rtl/immgen_pkg.sv | 19 +
 rtl/immgen_core.sv | 40 ++++
 rtl/immgen_pipe.sv | 129 ++++++++++++
 tb/tb_immgen_pipe.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/immgen_pkg.sv
// Shared constants for the registered immediate generator.
package immgen_pkg;

   // Immediate selector encodings presented on in_imm_type.
   localparam logic [2:0] IMM_I   = 3'd0;
   localparam logic [2:0] IMM_S   = 3'd1;
   localparam logic [2:0] IMM_B   = 3'd2;
   localparam logic [2:0] IMM_U   = 3'd3;
   localparam logic [2:0] IMM_J   = 3'd4;
   localparam logic [2:0] IMM_Z   = 3'd5;
   localparam logic [2:0] IMM_SH  = 3'd6;
   localparam logic [2:0] IMM_ILL = 3'd7;

   // Shift-amount field width: RV64 shifts use 6 bits, RV32 shifts use 5.
   function automatic int unsigned sh_width(input int unsigned xlen);
      return (xlen == 64) ? 6 : 5;
   endfunction

endpackage

// File: rtl/immgen_core.sv
// Combinational immediate extraction from a raw instruction word.
module immgen_core
   import immgen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     inst,
   input  logic [2:0]      imm_type,
   output logic [XLEN-1:0] imm,
   output logic            illegal
);

   localparam int unsigned SH_W = sh_width(XLEN);

   logic [5:0] sh_field;
   logic       unused_opcode;

   // The opcode bits never contribute to any immediate.
   assign unused_opcode = ^inst[6:0];

   // On RV32 the top shamt bit is not part of the shift amount.
   assign sh_field = (SH_W == 6) ? inst[25:20] : {1'b0, inst[24:20]};

   // Select and extend the immediate; size casts of signed operands sign-extend.
   always_comb begin
      imm     = '0;
      illegal = 1'b0;
      case (imm_type)
         IMM_I:   imm = XLEN'($signed(inst[31:20]));
         IMM_S:   imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         IMM_B:   imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         IMM_U:   imm = XLEN'($signed({inst[31:12], 12'b0}));
         IMM_J:   imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         IMM_Z:   imm = XLEN'(inst[19:15]);
         IMM_SH:  imm = XLEN'(sh_field);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/immgen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer between
// decode and execute.
//
// Handshake: an item moves across a port on every rising edge where its
// valid and ready are both high. A producer holds valid, payload and tag
// stable while valid is high and ready is low. in_ready is the inverted
// skid-valid flop, so it never depends combinationally on out_ready.
module immgen_pipe
   import immgen_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [2:0]       in_imm_type,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_illegal
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("immgen_pipe: XLEN must be 32 or 64");
   end

   logic [XLEN-1:0]  new_imm;
   logic             new_ill;

   // Output register (OR) and skid register (SR).
   logic             or_valid_q, or_valid_d;
   logic [XLEN-1:0]  or_imm_q,   or_imm_d;
   logic [TAG_W-1:0] or_tag_q,   or_tag_d;
   logic             or_ill_q,   or_ill_d;
   logic             sr_valid_q, sr_valid_d;
   logic [XLEN-1:0]  sr_imm_q,   sr_imm_d;
   logic [TAG_W-1:0] sr_tag_q,   sr_tag_d;
   logic             sr_ill_q,   sr_ill_d;

   logic             in_fire;
   logic             or_fire;
   logic             or_free;

   immgen_core #(.XLEN(XLEN)) u_core (
      .inst     (in_inst),
      .imm_type (in_imm_type),
      .imm      (new_imm),
      .illegal  (new_ill)
   );

   assign in_ready    = !sr_valid_q;
   assign out_valid   = or_valid_q;
   assign out_imm     = or_imm_q;
   assign out_tag     = or_tag_q;
   assign out_illegal = or_ill_q;

   // Anything offered during a flush is dropped, so it never counts as accepted.
   assign in_fire = in_valid && !sr_valid_q && !flush;
   assign or_fire = or_valid_q && out_ready;
   assign or_free = !or_valid_q || or_fire;

   // Next-state for OR/SR: flush wins, then refill OR from SR, then from input.
   always_comb begin
      or_valid_d = or_valid_q;
      or_imm_d   = or_imm_q;
      or_tag_d   = or_tag_q;
      or_ill_d   = or_ill_q;
      sr_valid_d = sr_valid_q;
      sr_imm_d   = sr_imm_q;
      sr_tag_d   = sr_tag_q;
      sr_ill_d   = sr_ill_q;
      if (flush) begin
         or_valid_d = 1'b0;
         sr_valid_d = 1'b0;
      end else if (or_free) begin
         if (sr_valid_q) begin
            // SR holds the older item; in_ready is low so nothing new arrives.
            or_valid_d = 1'b1;
            or_imm_d   = sr_imm_q;
            or_tag_d   = sr_tag_q;
            or_ill_d   = sr_ill_q;
            sr_valid_d = 1'b0;
         end else if (in_fire) begin
            or_valid_d = 1'b1;
            or_imm_d   = new_imm;
            or_tag_d   = in_tag;
            or_ill_d   = new_ill;
         end else begin
            or_valid_d = 1'b0;
         end
      end else if (in_fire) begin
         // OR is stalled, park the new item in SR.
         sr_valid_d = 1'b1;
         sr_imm_d   = new_imm;
         sr_tag_d   = in_tag;
         sr_ill_d   = new_ill;
      end
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         or_valid_q <= 1'b0;
         or_imm_q   <= '0;
         or_tag_q   <= '0;
         or_ill_q   <= 1'b0;
         sr_valid_q <= 1'b0;
         sr_imm_q   <= '0;
         sr_tag_q   <= '0;
         sr_ill_q   <= 1'b0;
      end else begin
         or_valid_q <= or_valid_d;
         or_imm_q   <= or_imm_d;
         or_tag_q   <= or_tag_d;
         or_ill_q   <= or_ill_d;
         sr_valid_q <= sr_valid_d;
         sr_imm_q   <= sr_imm_d;
         sr_tag_q   <= sr_tag_d;
         sr_ill_q   <= sr_ill_d;
      end
   end

endmodule

// File: tb/tb_immgen_pipe.sv
// Bench for immgen_pipe: an XLEN=32 and an XLEN=64 instance share one
// stimulus stream and are both checked against a queue-based model.
module tb_immgen_pipe;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic        in_valid = 1'b0;
   logic        out_ready = 1'b1;
   logic [31:0] in_inst = '0;
   logic [2:0]  in_type = '0;
   logic [7:0]  in_tag = '0;

   logic        rdy32, vld32, ill32, rdy64, vld64, ill64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [7:0]  tag32, tag64;

   int n_vec = 0;
   int n_err = 0;
   bit checking = 0;
   bit tag9_seen = 0;

   typedef struct packed {
      logic [31:0] inst;
      logic [2:0]  ty;
      logic [7:0]  tag;
   } item_t;
   item_t mq[$];

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   immgen_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy32),
      .in_inst(in_inst), .in_imm_type(in_type), .in_tag(in_tag), .out_valid(vld32),
      .out_ready(out_ready), .out_imm(imm32), .out_tag(tag32), .out_illegal(ill32)
   );

   immgen_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(rdy64),
      .in_inst(in_inst), .in_imm_type(in_type), .in_tag(in_tag), .out_valid(vld64),
      .out_ready(out_ready), .out_imm(imm64), .out_tag(tag64), .out_illegal(ill64)
   );

   // ---------------- reference immediate (arithmetic form) ----------------
   function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] ty,
                                           input bit x64);
      longint s;
      longint u;
      longint sgn;
      s   = longint'($signed(inst));
      u   = {32'b0, inst};
      sgn = s >>> 31;
      case (ty)
         3'd0: return s >>> 20;
         3'd1: return ((s >>> 25) <<< 5) | ((u >> 7) & 31);
         3'd2: return (sgn <<< 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5)
                      | (((u >> 8) & 15) << 1);
         3'd3: return s & 64'hFFFF_FFFF_FFFF_F000;
         3'd4: return (sgn <<< 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11)
                      | (((u >> 21) & 1023) << 1);
         3'd5: return (u >> 15) & 31;
         3'd6: return (u >> 20) & (x64 ? 63 : 31);
         default: return 64'd0;
      endcase
   endfunction

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic offer(input logic [31:0] i, input logic [2:0] t, input logic [7:0] g);
      in_valid = 1'b1;
      in_inst  = i;
      in_type  = t;
      in_tag   = g;
      step();
   endtask

   // ---------------- behavioural model: FIFO of capacity 2 ----------------
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
      end else if (flush) begin
         mq.delete();
      end else begin
         int cnt;
         cnt = mq.size();
         if (cnt > 0 && out_ready) void'(mq.pop_front());
         if (in_valid && cnt < 2) mq.push_back('{inst: in_inst, ty: in_type, tag: in_tag});
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (rst_n && checking) begin
         chk("in_ready32", {63'd0, rdy32}, {63'd0, mq.size() < 2});
         chk("in_ready64", {63'd0, rdy64}, {63'd0, mq.size() < 2});
         chk("out_valid32", {63'd0, vld32}, {63'd0, mq.size() > 0});
         chk("out_valid64", {63'd0, vld64}, {63'd0, mq.size() > 0});
         if (mq.size() > 0) begin
            chk("imm32", {32'd0, imm32}, {32'd0, ref_imm(mq[0].inst, mq[0].ty, 1'b0) & 64'hFFFF_FFFF});
            chk("imm64", imm64, ref_imm(mq[0].inst, mq[0].ty, 1'b1));
            chk("tag32", {56'd0, tag32}, {56'd0, mq[0].tag});
            chk("tag64", {56'd0, tag64}, {56'd0, mq[0].tag});
            chk("illegal32", {63'd0, ill32}, {63'd0, mq[0].ty == 3'd7});
            chk("illegal64", {63'd0, ill64}, {63'd0, mq[0].ty == 3'd7});
         end
      end
      if ((vld32 && tag32 == 8'd9) || (vld64 && tag64 == 8'd9)) tag9_seen = 1;
   end

   // ---------------- directed + random sequence ----------------
   initial begin
      bit acc;

      // Pin the reference model with hand-computed values.
      chk("ref_I32", ref_imm(32'hFFF00093, 3'd0, 1'b0) & 64'hFFFF_FFFF, 64'hFFFF_FFFF);
      chk("ref_B32", ref_imm(32'hFE000EE3, 3'd2, 1'b0) & 64'hFFFF_FFFF, 64'hFFFF_FFFC);
      chk("ref_J32", ref_imm(32'h0040006F, 3'd4, 1'b0) & 64'hFFFF_FFFF, 64'h4);
      chk("ref_U64", ref_imm(32'h800000B7, 3'd3, 1'b1), 64'hFFFF_FFFF_8000_0000);
      chk("ref_SH64", ref_imm(32'h03F0D093, 3'd6, 1'b1), 64'h3F);
      chk("ref_SH32", ref_imm(32'h03F0D093, 3'd6, 1'b0), 64'h1F);
      chk("ref_Z64", ref_imm(32'h000FD073, 3'd5, 1'b1), 64'h1F);
      chk("ref_S32", ref_imm(32'hFE000FA3, 3'd1, 1'b0) & 64'hFFFF_FFFF, 64'hFFFF_FFFF);

      // Reset values while rst_n is held low.
      #1;
      chk("rst_valid32", {63'd0, vld32}, 64'd0);
      chk("rst_valid64", {63'd0, vld64}, 64'd0);
      chk("rst_imm64", imm64, 64'd0);
      chk("rst_tag32", {56'd0, tag32}, 64'd0);
      chk("rst_ill32", {63'd0, ill32}, 64'd0);
      chk("rst_ready32", {63'd0, rdy32}, 64'd1);
      #21 rst_n = 1'b1;
      checking = 1;
      step();

      // Plan 1: back-to-back I, B, J at full throughput.
      offer(32'hFFF00093, 3'd0, 8'd11);
      chk("p1_imm_I", {32'd0, imm32}, 64'hFFFF_FFFF);
      offer(32'hFE000EE3, 3'd2, 8'd12);
      chk("p1_imm_B", {32'd0, imm32}, 64'hFFFF_FFFC);
      chk("p1_tag_B", {56'd0, tag32}, 64'd12);
      offer(32'h0040006F, 3'd4, 8'd13);
      in_valid = 1'b0;
      chk("p1_imm_J", {32'd0, imm32}, 64'h4);
      chk("p1_tag_J", {56'd0, tag32}, 64'd13);

      // Plan 2: 64-bit U, SH, Z.
      offer(32'h800000B7, 3'd3, 8'd21);
      chk("p2_imm_U", imm64, 64'hFFFF_FFFF_8000_0000);
      offer(32'h03F0D093, 3'd6, 8'd22);
      chk("p2_imm_SH", imm64, 64'h3F);
      offer(32'h000FD073, 3'd5, 8'd23);
      in_valid = 1'b0;
      chk("p2_imm_Z", imm64, 64'h1F);

      // Plan 4: illegal type, then a legal one.
      offer(32'h12345678, 3'd7, 8'd31);
      chk("p4_ill", {63'd0, ill32}, 64'd1);
      chk("p4_imm0", imm64, 64'd0);
      offer(32'hFFF00093, 3'd0, 8'd32);
      in_valid = 1'b0;
      chk("p4_legal", {63'd0, ill64}, 64'd0);
      step();

      // Plan 3: backpressure with tags 1, 2, 3.
      out_ready = 1'b0;
      offer(32'h00100093, 3'd0, 8'd1);
      offer(32'h00200093, 3'd0, 8'd2);
      in_valid = 1'b1;
      in_tag   = 8'd3;
      chk("p3_ready_low", {63'd0, rdy32}, 64'd0);
      step();
      chk("p3_hold_tag", {56'd0, tag32}, 64'd1);
      out_ready = 1'b1;
      step();
      chk("p3_tag2", {56'd0, tag32}, 64'd2);
      chk("p3_ready_back", {63'd0, rdy32}, 64'd1);
      step();
      in_valid = 1'b0;
      chk("p3_tag3", {56'd0, tag32}, 64'd3);
      step();

      // Plan 5: flush with both registers full and tag 9 offered.
      out_ready = 1'b0;
      offer(32'h00500093, 3'd0, 8'd5);
      offer(32'h00600093, 3'd0, 8'd6);
      in_valid = 1'b1;
      in_tag   = 8'd9;
      flush    = 1'b1;
      step();
      flush    = 1'b0;
      in_valid = 1'b0;
      chk("p5_valid", {63'd0, vld32}, 64'd0);
      chk("p5_ready", {63'd0, rdy64}, 64'd1);
      out_ready = 1'b1;
      step();

      // Plan 6: asynchronous reset mid-stream.
      out_ready = 1'b0;
      offer(32'h00700093, 3'd0, 8'd7);
      offer(32'h00800093, 3'd0, 8'd8);
      in_valid = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("p6_rst_valid32", {63'd0, vld32}, 64'd0);
      chk("p6_rst_valid64", {63'd0, vld64}, 64'd0);
      chk("p6_rst_ready", {63'd0, rdy32}, 64'd1);
      #2 rst_n = 1'b1;
      out_ready = 1'b1;
      step();
      offer(32'hFFF00093, 3'd0, 8'd42);
      in_valid = 1'b0;
      chk("p6_first_valid", {63'd0, vld32}, 64'd1);
      chk("p6_first_tag", {56'd0, tag64}, 64'd42);
      step();

      // Randomized traffic with backpressure and occasional flushes.
      for (int n = 0; n < 600; n++) begin
         acc = in_valid && rdy32 && !flush;
         if (acc || !in_valid || flush) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_inst  = $urandom;
            in_type  = 3'($urandom_range(0, 7));
            in_tag   = 8'($urandom_range(10, 255));
         end
         out_ready = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 39) == 0);
         step();
      end
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      step();
      step();
      step();

      chk("p5_tag9_never", {63'd0, tag9_seen}, 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
